// File: rtl/run8_pkg.sv
// run8_pkg: shared definitions for the running-light key controller.
//   - MODE_W and the mode constants MODE_OFF..MODE_ALLON
//   - the seed LED pattern loaded when each mode is entered
//   - the debounce FSM state encoding
//   - the ping-pong direction encoding
package run8_pkg;

    localparam int MODE_W = 4;

    localparam logic [MODE_W-1:0] MODE_OFF      = 4'd0;
    localparam logic [MODE_W-1:0] MODE_ROT_L    = 4'd1;
    localparam logic [MODE_W-1:0] MODE_ROT_R    = 4'd2;
    localparam logic [MODE_W-1:0] MODE_PINGPONG = 4'd3;
    localparam logic [MODE_W-1:0] MODE_ROT2_L   = 4'd4;
    localparam logic [MODE_W-1:0] MODE_FILL_L   = 4'd5;
    localparam logic [MODE_W-1:0] MODE_FILL_R   = 4'd6;
    localparam logic [MODE_W-1:0] MODE_CONVERGE = 4'd7;
    localparam logic [MODE_W-1:0] MODE_ALT      = 4'd8;
    localparam logic [MODE_W-1:0] MODE_BLINK    = 4'd9;
    localparam logic [MODE_W-1:0] MODE_CNT_UP   = 4'd10;
    localparam logic [MODE_W-1:0] MODE_CNT_DN   = 4'd11;
    localparam logic [MODE_W-1:0] MODE_DARK_ROT = 4'd12;
    localparam logic [MODE_W-1:0] MODE_ALLON    = 4'd13;

    localparam logic [7:0] SEED_OFF      = 8'h00;
    localparam logic [7:0] SEED_ROT_L    = 8'h01;
    localparam logic [7:0] SEED_ROT_R    = 8'h80;
    localparam logic [7:0] SEED_PINGPONG = 8'h01;
    localparam logic [7:0] SEED_ROT2_L   = 8'h03;
    localparam logic [7:0] SEED_FILL_L   = 8'h01;
    localparam logic [7:0] SEED_FILL_R   = 8'h80;
    localparam logic [7:0] SEED_CONVERGE = 8'h81;
    localparam logic [7:0] SEED_ALT      = 8'h55;
    localparam logic [7:0] SEED_BLINK    = 8'hFF;
    localparam logic [7:0] SEED_CNT_UP   = 8'h00;
    localparam logic [7:0] SEED_CNT_DN   = 8'hFF;
    localparam logic [7:0] SEED_DARK_ROT = 8'hFE;
    localparam logic [7:0] SEED_ALLON    = 8'hFF;

    typedef enum logic [1:0] {
        DB_IDLE       = 2'd0,
        DB_PRESS_WAIT = 2'd1,
        DB_PRESSED    = 2'd2,
        DB_REL_WAIT   = 2'd3
    } db_state_t;

    // For the converge pattern "left" means moving inward (81 -> 18).
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] v);
        return {v[0], v[7:1]};
    endfunction

endpackage

// File: rtl/run8_pattern.sv
// run8_pattern: combinational LED pattern generator.
//   seed_mode_i  in  4  mode whose seed pattern is wanted
//   seed_o       out 8  seed pattern for seed_mode_i
//   mode_i       in  4  mode currently running
//   led_i        in  8  current LED pattern
//   dir_i        in  1  current ping-pong / converge direction
//   led_nxt_o    out 8  pattern after one step
//   dir_nxt_o    out 1  direction after one step
// Modes outside 0..13 produce an all-off pattern.
module run8_pattern
    import run8_pkg::*;
(
    input  logic [MODE_W-1:0] seed_mode_i,
    output logic [7:0]        seed_o,
    input  logic [MODE_W-1:0] mode_i,
    input  logic [7:0]        led_i,
    input  logic              dir_i,
    output logic [7:0]        led_nxt_o,
    output logic              dir_nxt_o
);

    always_comb begin
        seed_o = 8'h00;
        case (seed_mode_i)
            MODE_OFF:      seed_o = SEED_OFF;
            MODE_ROT_L:    seed_o = SEED_ROT_L;
            MODE_ROT_R:    seed_o = SEED_ROT_R;
            MODE_PINGPONG: seed_o = SEED_PINGPONG;
            MODE_ROT2_L:   seed_o = SEED_ROT2_L;
            MODE_FILL_L:   seed_o = SEED_FILL_L;
            MODE_FILL_R:   seed_o = SEED_FILL_R;
            MODE_CONVERGE: seed_o = SEED_CONVERGE;
            MODE_ALT:      seed_o = SEED_ALT;
            MODE_BLINK:    seed_o = SEED_BLINK;
            MODE_CNT_UP:   seed_o = SEED_CNT_UP;
            MODE_CNT_DN:   seed_o = SEED_CNT_DN;
            MODE_DARK_ROT: seed_o = SEED_DARK_ROT;
            MODE_ALLON:    seed_o = SEED_ALLON;
            default:       seed_o = 8'h00;
        endcase
    end

    always_comb begin
        led_nxt_o = led_i;
        dir_nxt_o = dir_i;
        case (mode_i)
            MODE_OFF, MODE_ALLON: led_nxt_o = led_i;
            MODE_ROT_L, MODE_ROT2_L, MODE_DARK_ROT: led_nxt_o = rotl8(led_i);
            MODE_ROT_R: led_nxt_o = rotr8(led_i);
            MODE_PINGPONG: begin
                // Turn around at either end so no end value is shown twice.
                if (dir_i == DIR_LEFT) begin
                    if (led_i == 8'h80) begin
                        led_nxt_o = 8'h40;
                        dir_nxt_o = DIR_RIGHT;
                    end else begin
                        led_nxt_o = {led_i[6:0], 1'b0};
                    end
                end else begin
                    if (led_i == 8'h01) begin
                        led_nxt_o = 8'h02;
                        dir_nxt_o = DIR_LEFT;
                    end else begin
                        led_nxt_o = {1'b0, led_i[7:1]};
                    end
                end
            end
            MODE_FILL_L: led_nxt_o = (led_i == 8'hFF) ? 8'h00 : {led_i[6:0], 1'b1};
            MODE_FILL_R: led_nxt_o = (led_i == 8'hFF) ? 8'h00 : {1'b1, led_i[7:1]};
            MODE_CONVERGE: begin
                if (dir_i == DIR_LEFT) begin
                    case (led_i)
                        8'h81:   led_nxt_o = 8'h42;
                        8'h42:   led_nxt_o = 8'h24;
                        8'h24:   led_nxt_o = 8'h18;
                        8'h18: begin
                            led_nxt_o = 8'h24;
                            dir_nxt_o = DIR_RIGHT;
                        end
                        default: led_nxt_o = 8'h81;
                    endcase
                end else begin
                    case (led_i)
                        8'h18:   led_nxt_o = 8'h24;
                        8'h24:   led_nxt_o = 8'h42;
                        8'h42:   led_nxt_o = 8'h81;
                        8'h81: begin
                            led_nxt_o = 8'h42;
                            dir_nxt_o = DIR_LEFT;
                        end
                        default: begin
                            led_nxt_o = 8'h81;
                            dir_nxt_o = DIR_LEFT;
                        end
                    endcase
                end
            end
            MODE_ALT, MODE_BLINK: led_nxt_o = ~led_i;
            MODE_CNT_UP: led_nxt_o = led_i + 8'd1;
            MODE_CNT_DN: led_nxt_o = led_i - 8'd1;
            default: led_nxt_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/run8_key_ctrl.sv
// run8_key_ctrl: pushbutton debounce, mode stepping and running-light
// generation for the 2-digit display driver.
//   clk        in   1  system clock
//   rst        in   1  synchronous reset, active-high
//   key_n      in   1  raw pushbutton, active-low, asynchronous
//   mode       out  4  current mode (display data_in)
//   led        out  8  running-light pattern, 1 = LED on
//   key_pulse  out  1  one-cycle strobe per accepted press
// Build option: define RUN8_AUTOREPEAT_EN to emit a repeat key_pulse every
// REPEAT_CYC cycles while the key stays pressed.
//
// Strobe semantics: key_pulse is high for exactly one cycle; mode and led
// take their new values at the clock edge that ends that cycle. The debounce
// state is kept in state_q for observation.
module run8_key_ctrl
    import run8_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int STEP_CYC     = 10_000_000,
    parameter int MODE_MAX     = 13
`ifdef RUN8_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYC   = 25_000_000
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_n,
    output logic [MODE_W-1:0] mode,
    output logic [7:0]        led,
    output logic              key_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int STEP_W = $clog2(STEP_CYC + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_MAX);

    logic              sync1_q, sync2_q;
    db_state_t         state_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [STEP_W-1:0] step_cnt_q;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [7:0]        led_q;
    logic              dir_q;
    logic              db_pulse, rep_pulse, tick;
    logic [7:0]        seed, led_nxt;
    logic              dir_nxt;

    // Two-flop synchronizer; resets to the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM on the synchronized level (1 = released).
    // The counter is cleared on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DB_IDLE;
            db_cnt_q <= '0;
        end else begin
            case (state_q)
                DB_IDLE: begin
                    if (!sync2_q) begin
                        state_q  <= DB_PRESS_WAIT;
                        db_cnt_q <= '0;
                    end
                end
                DB_PRESS_WAIT: begin
                    if (sync2_q) begin
                        state_q  <= DB_IDLE;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q  <= DB_PRESSED;
                        db_cnt_q <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                DB_PRESSED: begin
                    if (sync2_q) begin
                        state_q  <= DB_REL_WAIT;
                        db_cnt_q <= '0;
                    end
                end
                DB_REL_WAIT: begin
                    if (!sync2_q) begin
                        state_q  <= DB_PRESSED;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q  <= DB_IDLE;
                        db_cnt_q <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                default: begin
                    state_q  <= DB_IDLE;
                    db_cnt_q <= '0;
                end
            endcase
        end
    end

    // The accepting cycle is the one that moves PRESS_WAIT to PRESSED.
    assign db_pulse = (state_q == DB_PRESS_WAIT) && !sync2_q && (db_cnt_q == DB_LAST);

`ifdef RUN8_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYC + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);
    logic [REP_W-1:0] rep_cnt_q;

    // Held at zero outside PRESSED, so every entry to PRESSED starts fresh.
    always_ff @(posedge clk) begin
        if (rst || state_q != DB_PRESSED || rep_cnt_q == REP_LAST) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_q + REP_W'(1);
        end
    end

    assign rep_pulse = (state_q == DB_PRESSED) && (rep_cnt_q == REP_LAST);
`else
    assign rep_pulse = 1'b0;
`endif

    // A press arriving while reset is asserted is discarded.
    assign key_pulse = (db_pulse | rep_pulse) & ~rst;
    assign tick      = (step_cnt_q == STEP_LAST);
    assign mode_d    = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);

    run8_pattern u_pattern (
        .seed_mode_i (mode_d),
        .seed_o      (seed),
        .mode_i      (mode_q),
        .led_i       (led_q),
        .dir_i       (dir_q),
        .led_nxt_o   (led_nxt),
        .dir_nxt_o   (dir_nxt)
    );

    // A key press takes priority over a coincident step tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= '0;
            led_q      <= 8'h00;
            dir_q      <= DIR_LEFT;
            step_cnt_q <= '0;
        end else if (key_pulse) begin
            mode_q     <= mode_d;
            led_q      <= seed;
            dir_q      <= DIR_LEFT;
            step_cnt_q <= '0;
        end else if (tick) begin
            led_q      <= led_nxt;
            dir_q      <= dir_nxt;
            step_cnt_q <= '0;
        end else begin
            step_cnt_q <= step_cnt_q + STEP_W'(1);
        end
    end

    assign mode = mode_q;
    assign led  = led_q;

endmodule

// File: tb/tb_run8_key_ctrl.sv
module tb_run8_key_ctrl;

    localparam int DB   = 4;
    localparam int STEP = 8;
    localparam int REP  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_n = 1'b1;
    logic [3:0] mode;
    logic [7:0] led;
    logic       key_pulse;

    always #5 clk = ~clk;

    run8_key_ctrl #(
        .DEBOUNCE_CYC (DB),
        .STEP_CYC     (STEP),
        .MODE_MAX     (13)
`ifdef RUN8_AUTOREPEAT_EN
        ,
        .REPEAT_CYC   (REP)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .mode      (mode),
        .led       (led),
        .key_pulse (key_pulse)
    );

    // Scoreboard: one expected {key_pulse, mode, led} per cycle.
    logic [12:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_pulses = 0;
    int dut_pulses = 0;

    // Reference model state (abstract: run lengths and step indices).
    bit m_valid = 0;
    bit m_s = 1, m_k1 = 1;   // key level seen 2 cycles / 1 cycle after drive
    bit m_acc = 0;           // accepted level, 1 = pressed
    int m_run = 0;           // consecutive samples disagreeing with m_acc
    int m_hold = 0;          // cycles settled in the pressed state
    int m_mode = 0;
    int m_k = 0;             // pattern steps since the mode was entered
    int m_ph = 0;            // cycles since last step

    function automatic int rotl(int x, int n);
        return ((x << n) | (x >> (8 - n))) & 255;
    endfunction

    function automatic logic [7:0] pat(int m, int k);
        int j, p, y;
        int conv[6] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h24, 8'h42};
        y = 0;
        case (m)
            0:  y = 0;
            1:  y = rotl(8'h01, k % 8);
            2:  y = rotl(8'h80, (8 - (k % 8)) % 8);
            3: begin
                p = k % 14;
                y = 1 << ((p < 8) ? p : 14 - p);
            end
            4:  y = rotl(8'h03, k % 8);
            5: begin
                j = k % 9;
                y = (j == 8) ? 0 : (1 << (j + 1)) - 1;
            end
            6: begin
                j = k % 9;
                y = (j == 8) ? 0 : (~(255 >> (j + 1))) & 255;
            end
            7:  y = conv[k % 6];
            8:  y = (k % 2) ? 8'hAA : 8'h55;
            9:  y = (k % 2) ? 8'h00 : 8'hFF;
            10: y = k % 256;
            11: y = 255 - (k % 256);
            12: y = rotl(8'hFE, k % 8);
            13: y = 255;
            default: y = 0;
        endcase
        return 8'(y);
    endfunction

    task automatic model_cycle(input bit r, input bit k);
        bit pr_s, db_p, in_pr, rep_p, pulse;
        pr_s  = (m_s == 1'b0);
        db_p  = !m_acc && pr_s && (m_run + 1 == DB + 1);
        in_pr = m_acc && (m_run == 0);
        rep_p = 1'b0;
`ifdef RUN8_AUTOREPEAT_EN
        rep_p = in_pr && (m_hold == REP - 1);
`endif
        pulse = (db_p || rep_p) && !r;
        if (m_valid) begin
            exp_q.push_back({pulse, 4'(m_mode), pat(m_mode, m_k)});
            if (pulse) exp_pulses++;
        end
        if (r) begin
            m_s = 1; m_k1 = 1; m_acc = 0; m_run = 0; m_hold = 0;
            m_mode = 0; m_k = 0; m_ph = 0; m_valid = 1;
        end else begin
            if (in_pr) m_hold = rep_p ? 0 : m_hold + 1;
            else m_hold = 0;
            if (pr_s != m_acc) begin
                m_run++;
                if (m_run == DB + 1) begin
                    m_acc = !m_acc;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            if (pulse) begin
                m_mode = (m_mode == 13) ? 0 : m_mode + 1;
                m_k = 0;
                m_ph = 0;
            end else if (m_ph == STEP - 1) begin
                m_ph = 0;
                m_k++;
            end else begin
                m_ph++;
            end
            m_s = m_k1;
            m_k1 = k;
        end
    endtask

    // Driver: set inputs for the coming cycle just after the edge.
    task automatic drive(input bit r, input bit k, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = r;
            key_n = k;
            cyc++;
            model_cycle(r, k);
        end
    endtask

    task automatic press(input int low, input int high);
        drive(1'b0, 1'b0, low);
        drive(1'b0, 1'b1, high);
    endtask

    // Monitor: compare every cycle against the scoreboard.
    initial begin
        logic [12:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {key_pulse, mode, led};
                if (key_pulse === 1'b1) dut_pulses++;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got pulse=%b mode=%0d led=%h expected pulse=%b mode=%0d led=%h",
                             cyc, a[12], a[11:8], a[7:0], e[12], e[11:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        int lvl, len;
        // Reset
        drive(1'b1, 1'b1, 3);
        drive(1'b0, 1'b1, 4);
        // Clean press
        press(10, 12);
        // Bounce
        drive(1'b1, 1'b1, 2);
        drive(1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 10);
        // Wrap: 14 presses from reset
        drive(1'b1, 1'b1, 2);
        for (int i = 0; i < 14; i++) press(7, 8);
        drive(1'b0, 1'b1, 10);
        // Mode 3 stepping, then presses at every step phase
        drive(1'b1, 1'b1, 2);
        for (int i = 0; i < 3; i++) press(7, 8);
        drive(1'b0, 1'b1, 130);
        for (int d = 0; d < 8; d++) begin
            drive(1'b0, 1'b1, d + 1);
            press(7, 9);
        end
        // Reset mid-PRESS_WAIT with key still held
        drive(1'b1, 1'b1, 2);
        drive(1'b0, 1'b0, 4);
        drive(1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 12);
        drive(1'b0, 1'b1, 10);
        // Reset mid-step
        press(7, 12);
        drive(1'b1, 1'b1, 1);
        drive(1'b0, 1'b1, 10);
        // Long hold (auto-repeat when enabled)
        drive(1'b1, 1'b1, 2);
        drive(1'b0, 1'b0, 60);
        drive(1'b0, 1'b1, 12);
        // Randomized key activity with occasional resets
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                drive(1'b1, 1'(lvl), $urandom_range(1, 2));
            end
            lvl = $urandom_range(0, 1);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 45) : $urandom_range(1, 9);
            drive(1'b0, 1'(lvl), len);
        end
        drive(1'b0, 1'b1, 20);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d pending expected 0", exp_q.size());
        end
        checks++;
        if (dut_pulses != exp_pulses) begin
            errors++;
            $display("FAIL pulse_count got %0d expected %0d", dut_pulses, exp_pulses);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
